// File: rtl/systolic_conv_engine.sv
// Tile convolution engine: OUT_N x OUT_N output-stationary MAC grid fed by a skewed operand
// wavefront, followed by shift/ReLU/saturation and a valid/ready row-major result stream.
module systolic_conv_engine #(
    parameter int DATA_W = 8,
    parameter int IMG_N  = 4,
    parameter int K      = 3,
    parameter int ACC_W  = 20,
    localparam int OUT_N  = IMG_N - K + 1,
    localparam int NPIX   = IMG_N * IMG_N,
    localparam int NOUT   = OUT_N * OUT_N,
    localparam int WA_W   = $clog2(NPIX),
    localparam int OIDX_W = (NOUT > 1) ? $clog2(NOUT) : 1,
    localparam int SH_W   = $clog2(ACC_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [WA_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic              signed_mode,
    input  logic              relu_en,
    input  logic [SH_W-1:0]   shift,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OIDX_W-1:0] out_idx,
    output logic              done
);
    localparam int KK      = K * K;
    localparam int RUN_CYC = KK + 2 * (OUT_N - 1) + 1;
    localparam int CYC_W   = $clog2(RUN_CYC);
    localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] S_MIN = ACC_W'(-(2 ** (DATA_W - 1)));
    localparam logic [ACC_W-1:0]        U_MAX = ACC_W'((2 ** DATA_W) - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [OIDX_W-1:0] idx_q, idx_d;
    logic              done_q, done_d;
    logic              sm_q, sm_d;
    logic              relu_q, relu_d;
    logic [SH_W-1:0]   shift_q, shift_d;

    logic [DATA_W-1:0] img_mem_q [NPIX];
    logic [DATA_W-1:0] ker_mem_q [NPIX];
    logic [ACC_W-1:0]  acc_arr    [NOUT];
    logic [DATA_W-1:0] ker_op_arr [NOUT];

    logic img_we, ker_we;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        sm_d    = sm_q;
        relu_d  = relu_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cyc_d   = '0;
                    sm_d    = signed_mode;
                    relu_d  = relu_en;
                    shift_d = shift;
                end
            end
            S_RUN: begin
                if (cyc_q == CYC_W'(RUN_CYC - 1)) begin
                    state_d = S_DRAIN;
                    cyc_d   = '0;
                    idx_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (idx_q == OIDX_W'(NOUT - 1)) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            sm_q    <= 1'b0;
            relu_q  <= 1'b0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            sm_q    <= sm_d;
            relu_q  <= relu_d;
            shift_q <= shift_d;
        end
    end

    // Only the first K*K kernel slots are ever read; writes beyond them are dropped.
    assign img_we = (state_q == S_IDLE) && wr_en && !wr_sel && (int'(wr_addr) < NPIX);
    assign ker_we = (state_q == S_IDLE) && wr_en &&  wr_sel && (int'(wr_addr) < KK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPIX; i++) begin
                img_mem_q[i] <= '0;
                ker_mem_q[i] <= '0;
            end
        end else begin
            if (img_we) img_mem_q[wr_addr] <= wr_data;
            if (ker_we) ker_mem_q[wr_addr] <= wr_data;
        end
    end

    for (genvar gi = 0; gi < NOUT; gi++) begin : g_pe
        localparam int PR = gi / OUT_N;
        localparam int PC = gi % OUT_N;

        logic [DATA_W-1:0]          img_op_q, img_op_d, ker_op_q, ker_op_d, ker_in;
        logic [ACC_W-1:0]           acc_q, acc_d;
        logic signed [DATA_W:0]     img_ext, ker_ext;
        logic signed [2*DATA_W+1:0] prod;
        logic signed [ACC_W-1:0]    prod_ext;
        int                         tap;

        // Kernel taps enter the top row and step down one PE per cycle; lower rows
        // simply take their upper neighbour's operand register.
        if (PR == 0) begin : g_top
            always_comb begin
                ker_in = '0;
                if (tap >= 0 && tap < KK) ker_in = ker_mem_q[WA_W'(tap)];
            end
        end else begin : g_below
            assign ker_in = ker_op_arr[gi - OUT_N];
        end

        // Horizontal neighbours need different pixels for the same tap, so each PE
        // fetches its own image operand on the skewed schedule.
        always_comb begin
            tap      = int'(cyc_q) - PR - PC;
            img_op_d = '0;
            ker_op_d = '0;
            if (state_q == S_RUN) begin
                ker_op_d = ker_in;
                if (tap >= 0 && tap < KK)
                    img_op_d = img_mem_q[WA_W'((PR + tap / K) * IMG_N + PC + tap % K)];
            end
        end

        assign img_ext  = {sm_q & img_op_q[DATA_W-1], img_op_q};
        assign ker_ext  = {sm_q & ker_op_q[DATA_W-1], ker_op_q};
        assign prod     = img_ext * ker_ext;
        assign prod_ext = ACC_W'(prod);

        always_comb begin
            acc_d = acc_q;
            if (state_q == S_IDLE && start) acc_d = '0;
            else if (state_q == S_RUN)      acc_d = acc_q + prod_ext;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                img_op_q <= '0;
                ker_op_q <= '0;
                acc_q    <= '0;
            end else begin
                img_op_q <= img_op_d;
                ker_op_q <= ker_op_d;
                acc_q    <= acc_d;
            end
        end

        assign acc_arr[gi]    = acc_q;
        assign ker_op_arr[gi] = ker_op_q;
    end

    logic [ACC_W-1:0]  acc_sel, shifted;
    logic [DATA_W-1:0] result;

    always_comb begin
        acc_sel = '0;
        for (int i = 0; i < NOUT; i++)
            if (idx_q == OIDX_W'(i)) acc_sel = acc_arr[i];
        if (sm_q) shifted = $signed(acc_sel) >>> shift_q;
        else      shifted = acc_sel >> shift_q;
        if (relu_q && sm_q && shifted[ACC_W-1]) shifted = '0;
        result = shifted[DATA_W-1:0];
        if (sm_q) begin
            if ($signed(shifted) > S_MAX)      result = {1'b0, {(DATA_W-1){1'b1}}};
            else if ($signed(shifted) < S_MIN) result = {1'b1, {(DATA_W-1){1'b0}}};
        end else if (shifted > U_MAX) begin
            result = '1;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DRAIN);
    assign out_data  = (state_q == S_DRAIN) ? result : '0;
    assign out_idx   = idx_q;
    assign done      = done_q;

endmodule

// File: tb/tb_systolic_conv_engine.sv
// Directed bench for systolic_conv_engine with the default 4x4 tile and 3x3 kernel.
module tb_systolic_conv_engine;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en, wr_sel;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       start, signed_mode, relu_en;
    logic [4:0] shift;
    logic       busy, out_valid, out_ready, done;
    logic [7:0] out_data;
    logic [1:0] out_idx;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    systolic_conv_engine dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .signed_mode(signed_mode), .relu_en(relu_en),
        .shift(shift), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input int addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 4'(addr);
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic fill(input logic sel, input int n, input logic [7:0] v);
        for (int i = 0; i < n; i++) wr(sel, i, v);
    endtask

    // Mode inputs are flipped right after the start edge to prove they were captured.
    task automatic run_job(input string tag, input logic sm, input logic relu, input logic [4:0] sh,
                           input int stall, input logic co_wr, input int co_addr,
                           input logic [7:0] co_data, input logic disturb,
                           input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] ev [4];
        int cnt;
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        out_ready   = (stall == 0);
        signed_mode = sm;
        relu_en     = relu;
        shift       = sh;
        start       = 1'b1;
        wr_en       = co_wr;
        wr_sel      = 1'b1;
        wr_addr     = 4'(co_addr);
        wr_data     = co_data;
        tick();
        start       = 1'b0;
        wr_en       = 1'b0;
        signed_mode = ~sm;
        relu_en     = ~relu;
        shift       = ~sh;
        check({tag, " busy"}, busy, 1);
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 40) begin
            if (disturb && cnt == 4) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_addr = 4'd0;
                wr_data = 8'd200;
            end else begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            tick();
            cnt++;
        end
        start = 1'b0;
        wr_en = 1'b0;
        check({tag, " latency"}, cnt, 12);
        for (int s = 0; s < stall; s++) begin
            check($sformatf("%s stall%0d valid", tag, s), out_valid, 1);
            check($sformatf("%s stall%0d data", tag, s), out_data, ev[0]);
            check($sformatf("%s stall%0d idx", tag, s), out_idx, 0);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s valid%0d", tag, i), out_valid, 1);
            check($sformatf("%s idx%0d", tag, i), out_idx, i);
            check($sformatf("%s data%0d", tag, i), out_data, ev[i]);
            check($sformatf("%s early_done%0d", tag, i), done, 0);
            tick();
        end
        check({tag, " done"}, done, 1);
        check({tag, " busy_end"}, busy, 0);
        check({tag, " valid_end"}, out_valid, 0);
        tick();
        check({tag, " done_pulse"}, done, 0);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; signed_mode = 1'b0; relu_en = 1'b0; shift = '0; out_ready = 1'b1;
        tick();
        tick();
        check("rst busy", busy, 0);
        check("rst out_valid", out_valid, 0);
        check("rst done", done, 0);
        check("rst out_data", out_data, 0);
        check("rst out_idx", out_idx, 0);
        rst_n = 1'b1;
        tick();

        fill(1'b0, 16, 8'd1);
        fill(1'b1, 9, 8'd1);
        run_job("ones", 0, 0, 5'd0, 0, 0, 0, 8'd0, 0, 8'd9, 8'd9, 8'd9, 8'd9);

        for (int i = 0; i < 16; i++) wr(1'b0, i, 8'(i + 1));
        fill(1'b1, 9, 8'd0);
        wr(1'b1, 4, 8'd1);
        run_job("center", 0, 0, 5'd0, 0, 0, 0, 8'd0, 0, 8'd6, 8'd7, 8'd10, 8'd11);

        fill(1'b1, 9, 8'd1);
        run_job("ramp_sh1", 0, 0, 5'd1, 0, 0, 0, 8'd0, 0, 8'd27, 8'd31, 8'd45, 8'd49);

        fill(1'b1, 9, 8'd0);
        wr(1'b1, 0, 8'd1);
        wr(1'b1, 8, 8'hFF);
        run_job("diag_s", 1, 0, 5'd0, 0, 0, 0, 8'd0, 0, 8'hF6, 8'hF6, 8'hF6, 8'hF6);
        run_job("diag_u", 0, 0, 5'd0, 0, 0, 0, 8'd0, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);

        fill(1'b0, 16, 8'd255);
        fill(1'b1, 9, 8'd255);
        run_job("sat_u", 0, 0, 5'd0, 0, 0, 0, 8'd0, 0, 8'd255, 8'd255, 8'd255, 8'd255);
        run_job("sh12_u", 0, 0, 5'd12, 0, 0, 0, 8'd0, 0, 8'd142, 8'd142, 8'd142, 8'd142);

        fill(1'b0, 16, 8'hFF);
        fill(1'b1, 9, 8'd1);
        run_job("neg_s", 1, 0, 5'd0, 0, 0, 0, 8'd0, 0, 8'hF7, 8'hF7, 8'hF7, 8'hF7);
        run_job("relu_s", 1, 1, 5'd0, 0, 0, 0, 8'd0, 0, 8'h00, 8'h00, 8'h00, 8'h00);

        fill(1'b0, 16, 8'd1);
        run_job("stall", 0, 0, 5'd0, 5, 0, 0, 8'd0, 1, 8'd9, 8'd9, 8'd9, 8'd9);
        run_job("rerun", 0, 0, 5'd0, 0, 0, 0, 8'd0, 0, 8'd9, 8'd9, 8'd9, 8'd9);
        run_job("co_write", 0, 0, 5'd0, 0, 1, 4, 8'd2, 0, 8'd10, 8'd10, 8'd10, 8'd10);

        signed_mode = 1'b0; relu_en = 1'b0; shift = '0; out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort out_valid", out_valid, 0);
        check("abort done", done, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_job("cleared", 0, 0, 5'd0, 0, 0, 0, 8'd0, 0, 8'd0, 8'd0, 8'd0, 8'd0);
        fill(1'b0, 16, 8'd1);
        fill(1'b1, 9, 8'd1);
        run_job("post_rst", 0, 0, 5'd0, 0, 0, 0, 8'd0, 0, 8'd9, 8'd9, 8'd9, 8'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
